id_stage_pipe: RTL

- Registered RISC-V instruction-decode pipeline stage for the next-generation core; parametrised in XLEN (32/64).
- Same field extraction as the existing decoder, plus: valid/ready handshake, full-throughput 2-entry skid buffer, flush, PC pass-through, illegal-opcode detection, and RV64 `*W` opcodes.
- Sits between fetch and execute.

---
 rtl/id_stage_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// Purpose : RISC-V instruction-decode pipeline stage (XLEN 32/64) with 2-entry skid buffer and flush.
// Latency : one cycle from in_fire to out_valid; full throughput with out_ready held high.
// Backpr. : up to two bundles held (main + skid); in_ready falls the cycle after the skid entry fills.
module id_stage_pipe #(
   parameter int              XLEN   = 32,
   parameter logic [XLEN-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_ins,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [11:0]     cbm_detect,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   localparam bit IS64 = (XLEN == 64);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [11:0]     cbm;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } bundle_t;

   bundle_t     r_m;
   bundle_t     r_k;
   logic        r_m_vld;
   logic        r_k_vld;

   bundle_t     w_dec;
   logic [31:0] w_imm32;
   logic        w_legal;
   logic        w_sb;
   logic        w_in_fire;
   logic        w_out_fire;

   assign in_ready   = !r_k_vld && !flush && !rst;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_m_vld && out_ready;

   // Combinational decode of the incoming instruction: immediate formed at 32 bits, then sign-extended.
   always_comb begin
      w_imm32 = '0;
      w_legal = 1'b0;
      w_sb    = 1'b0;
      case (in_ins[6:0])
         7'b1101111: begin
            w_imm32 = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
            w_legal = 1'b1;
         end
         7'b0110111, 7'b0010111: begin
            w_imm32 = {in_ins[31:12], 12'b0};
            w_legal = 1'b1;
         end
         7'b1100011: begin
            w_imm32 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
            w_legal = 1'b1;
            w_sb    = 1'b1;
         end
         7'b0100011: begin
            w_imm32 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
            w_legal = 1'b1;
            w_sb    = 1'b1;
         end
         7'b0000011, 7'b0010011, 7'b1100111: begin
            w_imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
            w_legal = 1'b1;
         end
         7'b0011011: begin
            // OP-IMM-32 only exists on RV64
            w_imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
            w_legal = IS64;
         end
         7'b0110011, 7'b0001111, 7'b1110011: begin
            w_legal = 1'b1;
         end
         7'b0111011: begin
            w_legal = IS64;
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
      // Compressed / malformed encodings are never legal here
      if (in_ins[1:0] != 2'b11) begin
         w_legal = 1'b0;
      end

      w_dec         = '0;
      w_dec.pc      = in_pc;
      w_dec.opcode  = in_ins[6:0];
      w_dec.rs1     = in_ins[19:15];
      w_dec.rs2     = in_ins[24:20];
      w_dec.rd      = w_sb ? 5'd0 : in_ins[11:7];
      w_dec.funct3  = in_ins[14:12];
      w_dec.funct7  = in_ins[31:25];
      w_dec.cbm     = in_ins[31:20];
      w_dec.imm     = w_legal ? XLEN'($signed(w_imm32)) : '0;
      w_dec.illegal = !w_legal;
   end

   // Main/skid register update: reset, then flush, then refill M from K or input, else park input in K.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_vld <= 1'b0;
         r_k_vld <= 1'b0;
         r_m     <= '0;
         r_m.pc  <= RST_PC;
         r_k     <= '0;
      end else if (flush) begin
         r_m_vld <= 1'b0;
         r_k_vld <= 1'b0;
      end else if (!r_m_vld || w_out_fire) begin
         if (r_k_vld) begin
            r_m     <= r_k;
            r_m_vld <= 1'b1;
            r_k_vld <= 1'b0;
         end else if (w_in_fire) begin
            r_m     <= w_dec;
            r_m_vld <= 1'b1;
         end else begin
            r_m_vld <= 1'b0;
         end
      end else if (w_in_fire) begin
         r_k     <= w_dec;
         r_k_vld <= 1'b1;
      end
   end

   assign out_valid  = r_m_vld;
   assign out_pc     = r_m_vld ? r_m.pc : RST_PC;
   assign opcode     = r_m.opcode;
   assign rs1        = r_m.rs1;
   assign rs2        = r_m.rs2;
   assign rd         = r_m.rd;
   assign funct3     = r_m.funct3;
   assign funct7     = r_m.funct7;
   assign cbm_detect = r_m.cbm;
   assign imm        = r_m.imm;
   assign illegal    = r_m.illegal;

endmodule
